div_unit: RTL and testbench
===========================

# div_unit

Multicycle signed 32-bit divider for the MIPS datapath, implementing `div`. It consumes the A and B register values and the control unit's `divControl` start strobe, and produces the quotient and remainder that the datapath writes into LO and HI. It flags division by zero so the control unit can select the divide-by-zero exception vector (0xFF) via `excpControl`.

## Interface
- `WIDTH`, 32, operand/result width; the datapath instantiates 32 only.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  driven by `divControl`; one-cycle request, sampled only in IDLE.
- `a`  in  WIDTH  dividend, from register A.
- `b`  in  WIDTH  divisor, from register B.
- `hi`  out  WIDTH  remainder, registered; feeds HI.
- `lo`  out  WIDTH  quotient, registered; feeds LO.
- `busy`  out  1  high while a division is in progress.
- `done`  out  1  one-cycle pulse when `hi`/`lo` have just been updated.
- `div_zero`  out  1  one-cycle pulse when a request had `b == 0`.

## Operation
- States: IDLE, RUN, FIN.
- Reset (`reset == 0` at an edge): state becomes IDLE, counter 0, `hi = lo = 0`, `busy = done = div_zero = 0`. Reset has priority over everything, including mid-operation.
- IDLE, `start == 0`: hold; `done` and `div_zero` drop to 0.
- IDLE, `start == 1`, `b == 0`:
  - Register `div_zero = 1` for one cycle.
  - Stay in IDLE; `hi`/`lo` keep their values; `busy` stays 0.
- IDLE, `start == 1`, `b != 0`, enter RUN and latch:
  - `|a|` into the quotient shift register.
  - `|b|` into the divisor register.
  - `sign_q = a[31] ^ b[31]` and `sign_r = a[31]`.
  - Partial remainder cleared (WIDTH+1 bits wide), counter = WIDTH, `busy = 1`.
  - Magnitudes are taken as unsigned WIDTH-bit values, so |0x80000000| = 0x80000000.
- RUN: one restoring step per edge.
  - Shift {rem, quo} left by 1.
  - Trial subtract the divisor from rem. If the result is non-negative, keep it and set quo[0] = 1; otherwise restore and set quo[0] = 0.
  - Decrement the counter. The step executed with counter == 1 moves the state to FIN.
- FIN:
  - `lo = sign_q ? -quo : quo`.
  - `hi = sign_r ? -rem : rem` (low WIDTH bits).
  - `done = 1`, `busy = 0`, return to IDLE.
- The result truncates toward zero, and the remainder takes the dividend's sign (MIPS semantics).
- 0x80000000 / 0xFFFFFFFF yields `lo = 0x80000000`, `hi = 0` (wraps, no trap).
- `start` is ignored while `busy == 1`. `a`/`b` changes after the start edge have no effect.
- `hi`/`lo` change only in FIN or on reset.

## Timing
- Let E0 be the edge that samples `start = 1` in IDLE.
- Valid divide: `busy` is high from E0 to E(WIDTH+1).
  - Steps occur at E1..E(WIDTH), i.e. E1..E32.
  - FIN is at E33: `hi`/`lo` update and `done` is high for the cycle E33 to E34.
  - Latency is WIDTH+1 = 33 cycles from the sampling edge to result valid.
- A new `start` is accepted at E34 at the earliest (the cycle in which `done` is high).
- Zero divisor: `div_zero` is high for the cycle E0 to E1. A new `start` is accepted at E1.
- Simultaneous `reset == 0` and `start == 1`: reset wins and no request is latched.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- `a = 7`, `b = 2`, start at E0 → `busy` is 1 during E0..E33; at E33 `lo = 3`, `hi = 1`, `done` pulses one cycle.
- `a = -7` (0xFFFFFFF9), `b = 2` → `lo = 0xFFFFFFFD`, `hi = 0xFFFFFFFF`. Then `a = 7`, `b = -2` → `lo = 0xFFFFFFFD`, `hi = 1`.
- `a = 0x80000000`, `b = 0xFFFFFFFF` → `lo = 0x80000000`, `hi = 0`. Then `a = 5`, `b = 9` → `lo = 0`, `hi = 5`.
- After a prior result `hi = 1`, `lo = 3`: `a = 123`, `b = 0`, start → `div_zero` high one cycle, `busy` stays 0, `hi = 1` and `lo = 3` unchanged, `done` never asserts.
- Start 100/7, toggle `start` and change `a`/`b` during RUN → extra starts are ignored; at E33 `lo = 14`, `hi = 2`.
- Start 100/7, drive `reset = 0` at E10 → all outputs are 0 at E10 with no `done` pulse. With reset released, start 9/3 → `lo = 3`, `hi = 0` exactly 33 cycles later.

Source files
------------

// File: rtl/div_unit.sv
// Multicycle signed restoring divider: quotient to lo, remainder to hi (MIPS div semantics).
// One restoring step per cycle; results land WIDTH+1 cycles after the accepted start.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]    rem_q, rem_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              div_zero_q, div_zero_d;

  // Restoring step datapath: shift {rem, quo} left, then trial-subtract the divisor.
  // The remainder stays below the divisor, so the trial result fits in WIDTH+1 bits.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (b == '0) begin
            div_zero_d = 1'b1;
          end else begin
            quo_d     = a[WIDTH-1] ? -a : a;
            dvs_d     = b[WIDTH-1] ? -b : b;
            neg_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
            neg_rem_d = a[WIDTH-1];
            rem_d     = '0;
            cnt_d     = CntW'(WIDTH);
            busy_d    = 1'b1;
            state_d   = StRun;
          end
        end
      end
      StRun: begin
        if (!trial[WIDTH]) begin
          rem_d = trial;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted;
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StFin;
        end
      end
      StFin: begin
        lo_d    = neg_quo_q ? -quo_q : quo_q;
        hi_d    = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed and random divides against a signed 64-bit arithmetic model.
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int tests = 0;
  int fails = 0;

  // Architectural state the model expects in HI/LO.
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MIPS div: truncate toward zero, remainder takes dividend's sign; 64-bit math
  // makes 0x80000000 / -1 wrap naturally to 0x80000000 with remainder 0.
  function automatic void model_div(input logic [31:0] da, input logic [31:0] db,
                                    output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    longint lq;
    longint lr;
    sa = longint'($signed(da));
    sb = longint'($signed(db));
    lq = sa / sb;
    lr = sa % sb;
    q  = lq[31:0];
    r  = lr[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller is at #1 after an edge; the next edge is E0.
  task automatic run_div(input string name, input logic [31:0] da, input logic [31:0] db);
    logic [31:0] q;
    logic [31:0] r;
    int n;
    start = 1'b1;
    a = da;
    b = db;
    tick();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    if (db == 0) begin
      tests++;
      if (div_zero !== 1'b1 || busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
        fails++;
        $display("FAIL %s zero: div_zero=%b busy=%b hi=%h lo=%h, want 1 0 %h %h",
                 name, div_zero, busy, hi, lo, exp_hi, exp_lo);
      end
      return;
    end
    model_div(da, db, q, r);
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL %s E0: busy=%b done=%b, want 1 0", name, busy, done);
    end
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done === 1'b1) begin
        n = i;
        break;
      end
      if (busy !== 1'b1 || lo !== exp_lo || hi !== exp_hi) begin
        tests++;
        fails++;
        $display("FAIL %s E%0d: busy=%b hi=%h lo=%h while running", name, i, busy, hi, lo);
      end
    end
    tests++;
    if (n != 33) begin
      fails++;
      $display("FAIL %s latency: got %0d cycles, want 33", name, n);
    end
    tests++;
    if (lo !== q || hi !== r || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s result: lo=%h hi=%h busy=%b, want lo=%h hi=%h busy=0",
               name, lo, hi, busy, q, r);
    end
    exp_lo = q;
    exp_hi = r;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1;
    a = 32'd7;
    b = 32'd2;
    tick();
    tick();
    tests++;
    if (hi !== 0 || lo !== 0 || busy !== 0 || done !== 0 || div_zero !== 0) begin
      fails++;
      $display("FAIL reset: hi=%h lo=%h busy=%b done=%b dz=%b, want all 0",
               hi, lo, busy, done, div_zero);
    end
    reset = 1'b1;
    start = 1'b0;
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_start_ignored: busy=%b want 0", busy);
    end
  endtask

  task automatic test_directed();
    run_div("7/2", 32'd7, 32'd2);
    run_div("-7/2", 32'hFFFF_FFF9, 32'd2);
    run_div("7/-2", 32'd7, 32'hFFFF_FFFE);
    run_div("min/-1", 32'h8000_0000, 32'hFFFF_FFFF);
    run_div("5/9", 32'd5, 32'd9);
    run_div("min/1", 32'h8000_0000, 32'd1);
    run_div("-1/min", 32'hFFFF_FFFF, 32'h8000_0000);
  endtask

  task automatic test_div_zero();
    run_div("7/2 pre", 32'd7, 32'd2);
    run_div("123/0", 32'd123, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (div_zero !== 0 || done !== 0 || busy !== 0 || hi !== 32'd1 || lo !== 32'd3) begin
        fails++;
        $display("FAIL div_zero_after %0d: dz=%b done=%b busy=%b hi=%h lo=%h",
                 i, div_zero, done, busy, hi, lo);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] q;
    logic [31:0] r;
    int n;
    model_div(32'd100, 32'd7, q, r);
    start = 1'b1;
    a = 32'd100;
    b = 32'd7;
    tick();
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      start = 1'($urandom);
      a = $urandom;
      b = $urandom_range(0, 3);
      tick();
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
    start = 1'b0;
    tests++;
    if (n != 33 || lo !== q || hi !== r) begin
      fails++;
      $display("FAIL ignore_start: cycles=%0d lo=%h hi=%h, want 33 %h %h", n, lo, hi, q, r);
    end
    exp_lo = q;
    exp_hi = r;
    // A start held during the done cycle could have been accepted; drain it.
    for (int i = 0; i < 40 && busy === 1'b1; i++) begin
      tick();
      if (done === 1'b1) begin
        exp_lo = lo;
        exp_hi = hi;
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    a = 32'd100;
    b = 32'd7;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tests++;
    if (hi !== 0 || lo !== 0 || busy !== 0 || done !== 0 || div_zero !== 0) begin
      fails++;
      $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b dz=%b, want all 0",
               hi, lo, busy, done, div_zero);
    end
    exp_hi = '0;
    exp_lo = '0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done !== 0 || busy !== 0) begin
        tests++;
        fails++;
        $display("FAIL reset_mid_quiet %0d: done=%b busy=%b, want 0 0", i, done, busy);
      end
    end
    run_div("9/3", 32'd9, 32'd3);
  endtask

  task automatic test_back_to_back();
    run_div("b2b 0", 32'd1000, 32'd0);
    run_div("b2b 1", 32'hFFFF_FC18, 32'd33);
    run_div("b2b 2", 32'd77, 32'hFFFF_FFF5);
  endtask

  task automatic test_random();
    logic [31:0] ra;
    logic [31:0] rb;
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 16));
        2: rb = -32'($urandom_range(1, 16));
        default: rb = $urandom;
      endcase
      if (i % 7 == 3) ra = 32'h8000_0000;
      run_div($sformatf("rand%0d", i), ra, rb);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    test_reset();
    test_directed();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
